// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with flush-over-freeze priority and bubble gating of ctrl.
// Optional bubble/stall statistics counters are enabled by defining IDEXE_STATS_EN.
module id_exe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rn_val_in,
  input  logic [31:0] rm_val_in,
  input  logic        imm_in,
  input  logic [11:0] shift_op_in,
  input  logic [23:0] signed_imm_in,
  input  logic [9:0]  ctrl_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic [3:0]  nzcv_in,
`ifdef IDEXE_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] bubble_cnt,
  output logic [15:0] stall_cnt,
`endif
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] rn_val_out,
  output logic [31:0] rm_val_out,
  output logic        imm_out,
  output logic [11:0] shift_op_out,
  output logic [23:0] signed_imm_out,
  output logic [9:0]  ctrl_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
  output logic [3:0]  nzcv_out
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic        imm;
    logic [11:0] shift_op;
    logic [23:0] signed_imm;
    logic [9:0]  ctrl;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  nzcv;
  } stage_t;

  stage_t stage_d, stage_q;

  // An all-zero stage is a bubble; ctrl is zeroed on invalid loads so valid=0 implies ctrl=0.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!freeze) begin
      stage_d.valid      = valid_in;
      stage_d.pc         = pc_in;
      stage_d.rn_val     = rn_val_in;
      stage_d.rm_val     = rm_val_in;
      stage_d.imm        = imm_in;
      stage_d.shift_op   = shift_op_in;
      stage_d.signed_imm = signed_imm_in;
      stage_d.ctrl       = valid_in ? ctrl_in : '0;
      stage_d.dest       = dest_in;
      stage_d.src1       = src1_in;
      stage_d.src2       = src2_in;
      stage_d.nzcv       = nzcv_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_out      = stage_q.valid;
  assign pc_out         = stage_q.pc;
  assign rn_val_out     = stage_q.rn_val;
  assign rm_val_out     = stage_q.rm_val;
  assign imm_out        = stage_q.imm;
  assign shift_op_out   = stage_q.shift_op;
  assign signed_imm_out = stage_q.signed_imm;
  assign ctrl_out       = stage_q.ctrl;
  assign dest_out       = stage_q.dest;
  assign src1_out       = stage_q.src1;
  assign src2_out       = stage_q.src2;
  assign nzcv_out       = stage_q.nzcv;

`ifdef IDEXE_STATS_EN
  logic [15:0] bubble_cnt_d, bubble_cnt_q;
  logic [15:0] stall_cnt_d,  stall_cnt_q;
  logic        bubble_inc;
  logic        stall_inc;

  always_comb begin
    bubble_inc   = flush || (!freeze && !valid_in);
    stall_inc    = freeze && !flush;
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (bubble_inc && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (stats_clr) begin
      bubble_cnt_d = '0;
      stall_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule
